conv_tile_scheduler: RTL and testbench
======================================

Name: conv_tile_scheduler

Overview:
Top-level sequencer for one convolution layer on the MAC_ROW x MAC_COL systolic array. It walks the channel-tile loop nest with the input-channel tile as the outer loop and the output-channel tile as the inner loop. For each tile it hands off to the weight loader, then to the compute/ifmap streaming engine. It exports the tile indices and an ofmap accumulate flag, and pulses done when the layer finishes.

Parameters:
MAC_ROW, 16, array rows; input channels per tile
MAC_COL, 16, array columns; output channels per tile
IFMAP_CHANNEL_NUM, 32, layer input channels; multiple of MAC_ROW
OFMAP_CHANNEL_NUM, 64, layer output channels; multiple of MAC_COL
CNT_BIT, 8, width of the tile-index outputs

Ports:
clk  in  1  clock; rising-edge
rstn  in  1  asynchronous active-low reset
start_in  in  1  layer start; sampled only in IDLE
w_load_start  out  1  one-cycle pulse requesting the weight load for the current tile
w_load_done  in  1  weight loader finished; sampled only in WAIT_W
cmp_start  out  1  one-cycle pulse starting compute for the current tile
cmp_done  in  1  compute finished; sampled only in WAIT_C
ich_tile  out  CNT_BIT  current input-channel tile index
och_tile  out  CNT_BIT  current output-channel tile index
acc_en  out  1  1 = accumulate into ofmap; 0 = overwrite
last_tile  out  1  current tile is the final tile of the layer
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at layer end

Behaviour:
- Derived constants: I_TILES = IFMAP_CHANNEL_NUM/MAC_ROW and O_TILES = OFMAP_CHANNEL_NUM/MAC_COL. Both are at least 1 and at most 2^CNT_BIT.
- Reset (asynchronous, rstn=0): state=IDLE, ich_tile=0, och_tile=0. All 1-bit outputs are 0.
- State machine: IDLE, LOAD_W, WAIT_W, CSTART, WAIT_C, NEXT, DONE.
- All outputs are registered or Moore-decoded from state. No input-to-output combinational path.
- IDLE: if start_in=1, clear both indices and go to LOAD_W. Otherwise stay.
- LOAD_W: w_load_start=1 for exactly this cycle. Go to WAIT_W.
- WAIT_W: stay until w_load_done=1, then go to CSTART.
- CSTART: cmp_start=1 for exactly this cycle. Go to WAIT_C.
- WAIT_C: stay until cmp_done=1, then go to NEXT.
- NEXT: if last_tile, go to DONE and leave the indices unchanged. Otherwise:
  - if och_tile=O_TILES-1, set och_tile=0 and increment ich_tile;
  - else increment och_tile.
  - Then go to LOAD_W.
- DONE: done=1 for one cycle. Go to IDLE. Indices hold their final values until the next start.
- Latency: start to first w_load_start is 1 cycle. If each done input is high on the first WAIT cycle, each tile takes 5 cycles (LOAD_W, WAIT_W, CSTART, WAIT_C, NEXT).
- Total cycles from start sample to done pulse = 1 + I_TILES*O_TILES*5 - 1 + 1, plus any extra wait cycles.
- acc_en = (ich_tile != 0); it is stable for the whole tile.
- last_tile = (ich_tile=I_TILES-1) && (och_tile=O_TILES-1).
- ich_tile, och_tile, acc_en and last_tile only change on leaving NEXT or IDLE. They are stable from LOAD_W through WAIT_C.
- Boundary conditions:
  - start_in while busy is ignored; no restart and no queueing.
  - w_load_done or cmp_done asserted outside its WAIT state is ignored and not remembered.
  - A done input held high continuously is legal; each tile then takes the minimum 5 cycles.
  - I_TILES=O_TILES=1: exactly one tile with acc_en=0, followed by DONE.
  - rstn deasserted mid-layer: immediate return to the reset values. Any pulse in flight is cut. No done pulse.
  - start_in high in the same cycle as the DONE state is ignored, because the FSM is not yet in IDLE.

Test Plan:
- Default params (I_TILES=2, O_TILES=4); start pulse; loader done after 3 cycles, compute done after 5 -> 8 w_load_start and 8 cmp_start pulses with (ich,och) = (0,0..3) then (1,0..3); acc_en=0 for the first 4 tiles and 1 for the last 4; last_tile only on (1,3); exactly one done pulse; busy low afterwards.
- Default params, w_load_done and cmp_done tied high -> done pulse exactly 41 cycles after the start sample edge; w_load_start spacing 5 cycles.
- Start re-pulsed during WAIT_C of tile 2, plus cmp_done pulsed in IDLE and w_load_done pulsed in WAIT_C -> sequence identical to the first scenario; no extra pulses.
- Params IFMAP_CHANNEL_NUM=16, OFMAP_CHANNEL_NUM=16 -> single tile (0,0), acc_en=0, last_tile=1, one done pulse.
- rstn pulsed low in WAIT_W of tile 5 -> all outputs 0 immediately; no done pulse; a new start runs the full 8-tile sequence from (0,0).
- Back-to-back layers: start asserted in the first IDLE cycle after done -> the second layer begins cleanly with indices cleared to (0,0).

Source files
------------

// File: rtl/conv_tile_scheduler.sv
// Convolution layer tile sequencer: walks input-channel tiles (outer loop) and
// output-channel tiles (inner loop), handing each tile to the weight loader and
// then to the compute engine, and pulses done at the end of the layer.
module conv_tile_scheduler #(
    parameter int unsigned MAC_ROW           = 16,
    parameter int unsigned MAC_COL           = 16,
    parameter int unsigned IFMAP_CHANNEL_NUM = 32,
    parameter int unsigned OFMAP_CHANNEL_NUM = 64,
    parameter int unsigned CNT_BIT           = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_in,
    output logic               w_load_start,
    input  logic               w_load_done,
    output logic               cmp_start,
    input  logic               cmp_done,
    output logic [CNT_BIT-1:0] ich_tile,
    output logic [CNT_BIT-1:0] och_tile,
    output logic               acc_en,
    output logic               last_tile,
    output logic               busy,
    output logic               done
);

    localparam int unsigned I_TILES = IFMAP_CHANNEL_NUM / MAC_ROW;
    localparam int unsigned O_TILES = OFMAP_CHANNEL_NUM / MAC_COL;
    localparam logic [CNT_BIT-1:0] I_LAST = CNT_BIT'(I_TILES - 1);
    localparam logic [CNT_BIT-1:0] O_LAST = CNT_BIT'(O_TILES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StWaitW,
        StCStart,
        StWaitC,
        StNext,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_BIT-1:0] ich_q, ich_d;
    logic [CNT_BIT-1:0] och_q, och_d;
    // Registered so it reads 0 out of reset even for a single-tile layer.
    logic               last_q, last_d;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_in) state_d = StLoadW;
            StLoadW:  state_d = StWaitW;
            StWaitW:  if (w_load_done) state_d = StCStart;
            StCStart: state_d = StWaitC;
            StWaitC:  if (cmp_done) state_d = StNext;
            StNext:   state_d = last_q ? StDone : StLoadW;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Tile index registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ich_q  <= '0;
            och_q  <= '0;
            last_q <= 1'b0;
        end else begin
            ich_q  <= ich_d;
            och_q  <= och_d;
            last_q <= last_d;
        end
    end

    // Tile index advance: clear on start, step the loop nest on leaving NEXT
    always_comb begin
        ich_d  = ich_q;
        och_d  = och_q;
        last_d = last_q;
        if (state_q == StIdle && start_in) begin
            ich_d  = '0;
            och_d  = '0;
            last_d = (I_LAST == '0) && (O_LAST == '0);
        end else if (state_q == StNext && !last_q) begin
            if (och_q == O_LAST) begin
                och_d = '0;
                ich_d = ich_q + 1'b1;
            end else begin
                och_d = och_q + 1'b1;
            end
            last_d = (ich_d == I_LAST) && (och_d == O_LAST);
        end
    end

    // Moore outputs decoded from state and index registers
    always_comb begin
        w_load_start = (state_q == StLoadW);
        cmp_start    = (state_q == StCStart);
        busy         = (state_q != StIdle);
        done         = (state_q == StDone);
        ich_tile     = ich_q;
        och_tile     = och_q;
        acc_en       = (ich_q != '0);
        last_tile    = last_q;
    end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Randomized self-checking bench for conv_tile_scheduler. A default-parameter
// instance runs several layers; a second single-tile instance covers the
// degenerate layer shape.
module tb_conv_tile_scheduler;

    localparam int IT = 2;
    localparam int OT = 4;
    localparam int NT = IT * OT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, start_in, w_load_done, cmp_done;
    logic       w_load_start, cmp_start, acc_en, last_tile, busy, done;
    logic [7:0] ich_tile, och_tile;

    logic       start1;
    logic       w_load_start1, cmp_start1, acc_en1, last_tile1, busy1, done1;
    logic [7:0] ich_tile1, och_tile1;

    int n_chk  = 0;
    int n_fail = 0;

    conv_tile_scheduler dut (
        .clk          (clk),
        .rstn         (rstn),
        .start_in     (start_in),
        .w_load_start (w_load_start),
        .w_load_done  (w_load_done),
        .cmp_start    (cmp_start),
        .cmp_done     (cmp_done),
        .ich_tile     (ich_tile),
        .och_tile     (och_tile),
        .acc_en       (acc_en),
        .last_tile    (last_tile),
        .busy         (busy),
        .done         (done)
    );

    conv_tile_scheduler #(
        .IFMAP_CHANNEL_NUM (16),
        .OFMAP_CHANNEL_NUM (16)
    ) dut1 (
        .clk          (clk),
        .rstn         (rstn),
        .start_in     (start1),
        .w_load_start (w_load_start1),
        .w_load_done  (1'b1),
        .cmp_start    (cmp_start1),
        .cmp_done     (1'b1),
        .ich_tile     (ich_tile1),
        .och_tile     (och_tile1),
        .acc_en       (acc_en1),
        .last_tile    (last_tile1),
        .busy         (busy1),
        .done         (done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference loop nest: tile n is (n / O_TILES, n % O_TILES)
    function automatic int exp_ich(input int n);
        return n / OT;
    endfunction
    function automatic int exp_och(input int n);
        return n % OT;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_wls"},  w_load_start, 0);
        check({tag, "_cms"},  cmp_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_acc"},  acc_en, 0);
        check({tag, "_last"}, last_tile, 0);
        check({tag, "_ich"},  ich_tile, 0);
        check({tag, "_och"},  och_tile, 0);
    endtask

    // Run one layer on dut, starting at a negedge with the FSM in IDLE.
    // wdly/cdly: response delays (0 = random 1..4). tie_high: both done inputs
    // held high. noise: stray start/done inputs. abort_at: tile to reset in.
    task automatic run_layer(input int wdly, input int cdly, input bit tie_high,
                             input bit noise, input int abort_at);
        int cyc = 0, n_w = 0, n_c = 0, wcnt = 0, ccnt = 0, cur;
        bit seen_done = 1'b0;
        start_in    = 1'b1;
        w_load_done = tie_high | noise;
        cmp_done    = tie_high | noise;
        while (!seen_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start_in    = 1'b0;
            w_load_done = tie_high;
            cmp_done    = tie_high;
            check("busy_in_layer", busy, 1);
            if (w_load_start) begin
                if (tie_high) check("w_spacing", cyc, 1 + 5 * n_w);
                check("w_ich", ich_tile, exp_ich(n_w));
                check("w_och", och_tile, exp_och(n_w));
                n_w++;
                wcnt = (wdly != 0) ? wdly : $urandom_range(1, 4);
            end
            if (n_w > 0) begin
                cur = n_w - 1;
                check("tile_ich", ich_tile, exp_ich(cur));
                check("tile_och", och_tile, exp_och(cur));
                check("tile_acc", acc_en, (exp_ich(cur) != 0) ? 1 : 0);
                check("tile_last", last_tile,
                      (exp_ich(cur) == IT - 1 && exp_och(cur) == OT - 1) ? 1 : 0);
            end
            if (cmp_start) begin
                check("c_ich", ich_tile, exp_ich(n_c));
                check("c_och", och_tile, exp_och(n_c));
                n_c++;
                ccnt = (cdly != 0) ? cdly : $urandom_range(1, 4);
            end
            if (done) begin
                seen_done = 1'b1;
                check("w_count", n_w, NT);
                check("c_count", n_c, NT);
                if (tie_high) check("done_latency", cyc, 41);
                start_in = noise;
            end
            // Reset in the first WAIT_W cycle of the chosen tile
            if (abort_at >= 0 && n_w == abort_at + 1 && wcnt > 0 && !w_load_start) begin
                check("abort_w_pending", wcnt, wcnt);
                rstn = 1'b0;
                #1;
                check_all_zero("abort");
                @(negedge clk);
                check_all_zero("abort_hold");
                rstn        = 1'b1;
                start_in    = 1'b0;
                w_load_done = 1'b0;
                cmp_done    = 1'b0;
                return;
            end
            if (!tie_high && wcnt > 0 && !w_load_start) begin
                wcnt--;
                if (wcnt == 0) w_load_done = 1'b1;
            end
            if (!tie_high && ccnt > 0 && !cmp_start) begin
                ccnt--;
                if (ccnt == 0) cmp_done = 1'b1;
            end
            // Stray start and loader-done while compute is outstanding
            if (noise && ccnt > 0) begin
                start_in    = 1'b1;
                w_load_done = 1'b1;
            end
        end
        if (!seen_done) check("done_timeout", 0, 1);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_wls", w_load_start, 0);
        check("idle_cms", cmp_start, 0);
        check("idle_ich_hold", ich_tile, IT - 1);
        check("idle_och_hold", och_tile, OT - 1);
        start_in    = 1'b0;
        w_load_done = 1'b0;
        cmp_done    = 1'b0;
    endtask

    // Single-tile layer on dut1 with done inputs tied high
    task automatic run_single();
        start1 = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            start1 = 1'b0;
            check("s_wls", w_load_start1, (cyc == 1) ? 1 : 0);
            check("s_cms", cmp_start1, (cyc == 3) ? 1 : 0);
            check("s_done", done1, (cyc == 6) ? 1 : 0);
            check("s_busy", busy1, (cyc <= 6) ? 1 : 0);
            check("s_ich", ich_tile1, 0);
            check("s_och", och_tile1, 0);
            check("s_acc", acc_en1, 0);
            check("s_last", last_tile1, 1);
        end
    endtask

    initial begin
        rstn        = 1'b0;
        start_in    = 1'b0;
        w_load_done = 1'b0;
        cmp_done    = 1'b0;
        start1      = 1'b0;
        #1;
        check_all_zero("reset");
        check("reset1_last", last_tile1, 0);
        check("reset1_busy", busy1, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        run_layer(3, 5, 1'b0, 1'b0, -1);
        run_layer(0, 0, 1'b1, 1'b0, -1);
        run_layer(0, 0, 1'b0, 1'b1, -1);
        run_layer(0, 0, 1'b0, 1'b0, 5);
        run_layer(0, 0, 1'b0, 1'b0, -1);
        run_layer(0, 0, 1'b0, 1'b0, -1);
        run_single();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
